// File: rtl/mem_lsu_if.sv
// Client/memory bundle for the single-outstanding load/store unit.
// slave is the LSU's view; master is the client-plus-memory side that drives it.
interface mem_lsu_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [WIDTH-1:0]      req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  rsp_err;
    logic                  mem_mode;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_mode, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_mode, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time, checked for alignment and range,
// issued to a fixed-latency word memory, answered with a held response.
module mem_lsu #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int MEMORY_DEPTH = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    mem_lsu_if.slave    bus,
    output logic [15:0] cnt_rd_o,
    output logic [15:0] cnt_wr_o,
    output logic [15:0] cnt_err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [31:0] BYTE_LIMIT = 32'(MEMORY_DEPTH) * 32'd4;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [2:0]            wait_q, wait_d;
    logic [15:0]           cnt_rd_q, cnt_rd_d;
    logic [15:0]           cnt_wr_q, cnt_wr_d;
    logic [15:0]           cnt_err_q, cnt_err_d;
    logic                  req_bad;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign req_bad = (bus.req_addr[1:0] != 2'b00) || (32'(bus.req_addr) >= BYTE_LIMIT);

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wait_d    = wait_q;
        cnt_rd_d  = cnt_rd_q;
        cnt_wr_d  = cnt_wr_q;
        cnt_err_d = cnt_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    if (req_bad) begin
                        // Rejected requests never touch the memory port registers.
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ISSUE;
                        err_d   = 1'b0;
                        addr_d  = bus.req_addr[ADDR_WIDTH+1:2];
                        wdata_d = bus.req_wdata;
                    end
                end
            end
            ISSUE: begin
                if (write_q) begin
                    state_d = RESP;
                    rdata_d = '0;
                end else begin
                    state_d = WAIT;
                    wait_d  = 3'(READ_LATENCY);
                end
            end
            WAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q == 3'd1) begin
                    state_d = RESP;
                    rdata_d = bus.mem_rdata;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    if (err_q)        cnt_err_d = sat_inc(cnt_err_q);
                    else if (write_q) cnt_wr_d  = sat_inc(cnt_wr_q);
                    else              cnt_rd_d  = sat_inc(cnt_rd_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wait_q    <= 3'd0;
            cnt_rd_q  <= 16'd0;
            cnt_wr_q  <= 16'd0;
            cnt_err_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wait_q    <= wait_d;
            cnt_rd_q  <= cnt_rd_d;
            cnt_wr_q  <= cnt_wr_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    // Write strobe is decoded from state so an asynchronous reset drops it at once.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_mode  = (state_q == ISSUE) && write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign cnt_rd_o  = cnt_rd_q;
    assign cnt_wr_o  = cnt_wr_q;
    assign cnt_err_o = cnt_err_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a READ_LATENCY=1 instance with a 13-bit byte address
// (so 0x1000 is expressible) and a default-width READ_LATENCY=3 instance.
module tb_mem_lsu;
    localparam int RL1 = 1;
    localparam int RL2 = 3;

    logic clk = 1'b0;
    logic reset1, reset2, init_mem;
    logic [15:0] c1_rd, c1_wr, c1_err, c2_rd, c2_wr, c2_err;

    mem_lsu_if #(.WIDTH(32), .ADDR_WIDTH(11)) b1 ();
    mem_lsu_if #(.WIDTH(32), .ADDR_WIDTH(10)) b2 ();

    mem_lsu #(.WIDTH(32), .ADDR_WIDTH(11), .MEMORY_DEPTH(1024), .READ_LATENCY(RL1)) u_dut1 (
        .clk_i(clk), .reset_i(reset1), .bus(b1.slave),
        .cnt_rd_o(c1_rd), .cnt_wr_o(c1_wr), .cnt_err_o(c1_err));

    mem_lsu #(.WIDTH(32), .ADDR_WIDTH(10), .MEMORY_DEPTH(1024), .READ_LATENCY(RL2)) u_dut2 (
        .clk_i(clk), .reset_i(reset2), .bus(b2.slave),
        .cnt_rd_o(c2_rd), .cnt_wr_o(c2_wr), .cnt_err_o(c2_err));

    always #5 clk = ~clk;

    function automatic logic [31:0] hash(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30F17;
    endfunction

    // Memory behind dut1: one-cycle registered read.
    logic [31:0] slave1 [0:2047];
    logic [31:0] pipe1;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 2048; i++) slave1[i] <= hash(i);
        end else if (b1.mem_mode) begin
            slave1[b1.mem_addr] <= b1.mem_wdata;
        end
        pipe1 <= slave1[b1.mem_addr];
    end
    assign b1.mem_rdata = pipe1;

    // Memory behind dut2: three-stage read whose data is tagged with the cycle
    // the address was sampled, so a wrong sampling cycle returns a wrong word.
    int tick = 0;
    logic [31:0] slave2 [0:1023];
    logic [31:0] p2 [0:2];
    always @(posedge clk) begin
        tick <= tick + 1;
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) slave2[i] <= hash(i + 5000);
        end else if (b2.mem_mode) begin
            slave2[b2.mem_addr] <= b2.mem_wdata;
        end
        p2[0] <= slave2[b2.mem_addr] + 32'(tick);
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign b2.mem_rdata = p2[2];

    int wr_pulses1 = 0;
    always @(negedge clk) if (b1.mem_mode === 1'b1) wr_pulses1 <= wr_pulses1 + 1;

    // Reference model state
    logic [31:0] ref1 [0:1023];
    logic [31:0] ref2 [0:1023];
    int          m_rd, m_wr, m_err, m2_rd;
    logic [10:0] last_iss;
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    task automatic garbage_req1();
        b1.req_valid = 1'($urandom);
        b1.req_write = 1'($urandom);
        b1.req_addr  = 13'($urandom);
        b1.req_wdata = $urandom;
    endtask

    // One complete transaction on dut1, called and returning at a falling edge.
    task automatic txn(input logic wr, input logic [12:0] addr, input logic [31:0] wd, input int hold);
        logic        exp_err;
        int          exp_lat, lat, pulses0;
        logic [31:0] exp_data, r_data;
        logic        r_err;
        exp_err  = (addr[1:0] != 2'b00) || (addr >= 13'h1000);
        exp_lat  = exp_err ? 1 : (wr ? 2 : 2 + RL1);
        exp_data = (exp_err || wr) ? 32'h0 : ref1[addr[11:2]];
        pulses0  = wr_pulses1;
        check("req_ready_idle", 32'(b1.req_ready), 32'd1);
        b1.req_valid = 1'b1; b1.req_write = wr; b1.req_addr = addr; b1.req_wdata = wd;
        @(negedge clk);
        lat = 1;
        check("mem_addr_after_accept", 32'(b1.mem_addr), exp_err ? 32'(last_iss) : 32'(addr[12:2]));
        while (b1.rsp_valid !== 1'b1 && lat < 20) begin
            garbage_req1();
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(b1.rsp_err), 32'(exp_err));
        check("rsp_rdata", b1.rsp_rdata, exp_data);
        r_data = b1.rsp_rdata;
        r_err  = b1.rsp_err;
        for (int k = 0; k < hold; k++) begin
            b1.rsp_ready = 1'b0;
            garbage_req1();
            @(negedge clk);
            check("hold_rsp_valid", 32'(b1.rsp_valid), 32'd1);
            check("hold_rsp_rdata", b1.rsp_rdata, r_data);
            check("hold_rsp_err", 32'(b1.rsp_err), 32'(r_err));
            check("hold_req_ready", 32'(b1.req_ready), 32'd0);
        end
        b1.rsp_ready = 1'b1;
        garbage_req1();
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        b1.req_valid = 1'b0;
        check("rsp_valid_after_hs", 32'(b1.rsp_valid), 32'd0);
        if (exp_err) m_err = sat(m_err);
        else if (wr) m_wr = sat(m_wr);
        else m_rd = sat(m_rd);
        if (!exp_err) last_iss = addr[12:2];
        if (!exp_err && wr) ref1[addr[11:2]] = wd;
        check("cnt_rd", 32'(c1_rd), 32'(m_rd));
        check("cnt_wr", 32'(c1_wr), 32'(m_wr));
        check("cnt_err", 32'(c1_err), 32'(m_err));
        check("mem_write_pulses", 32'(wr_pulses1 - pulses0), (!exp_err && wr) ? 32'd1 : 32'd0);
    endtask

    task automatic load2(input logic [11:0] addr);
        int          lat;
        logic [31:0] exp_data;
        check("dut2_req_ready", 32'(b2.req_ready), 32'd1);
        b2.req_valid = 1'b1; b2.req_write = 1'b0; b2.req_addr = addr; b2.req_wdata = $urandom;
        @(negedge clk);
        b2.req_valid = 1'b0;
        exp_data = ref2[addr[11:2]] + 32'(tick);
        lat = 1;
        while (b2.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("dut2_latency", 32'(lat), 32'(2 + RL2));
        check("dut2_rdata", b2.rsp_rdata, exp_data);
        check("dut2_err", 32'(b2.rsp_err), 32'd0);
        b2.rsp_ready = 1'b1;
        @(negedge clk);
        b2.rsp_ready = 1'b0;
        m2_rd = sat(m2_rd);
        check("dut2_cnt_rd", 32'(c2_rd), 32'(m2_rd));
    endtask

    task automatic reset_model1();
        m_rd = 0; m_wr = 0; m_err = 0; last_iss = '0;
    endtask

    initial begin
        logic [12:0] a;
        int          kind;
        reset1 = 1'b0; reset2 = 1'b0; init_mem = 1'b1;
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.rsp_ready = 1'b0;
        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0; b2.rsp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ref1[i] = hash(i);
            ref2[i] = hash(i + 5000);
        end
        reset_model1();
        m2_rd = 0;
        #1 reset1 = 1'b1; reset2 = 1'b1;
        #1;
        check("rst_req_ready", 32'(b1.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        check("rst_rsp_rdata", b1.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(b1.rsp_err), 32'd0);
        check("rst_mem_mode", 32'(b1.mem_mode), 32'd0);
        check("rst_mem_addr", 32'(b1.mem_addr), 32'd0);
        check("rst_mem_wdata", b1.mem_wdata, 32'd0);
        check("rst_counters", {8'd0, 8'(c1_rd | c1_wr | c1_err)}, 32'd0);
        @(negedge clk);
        init_mem = 1'b0; reset1 = 1'b0; reset2 = 1'b0;

        // Store then load the same word
        txn(1'b1, 13'h010, 32'hDEADBEEF, 0);
        txn(1'b0, 13'h010, 32'h0, 0);
        check("load_back_deadbeef", ref1[4], 32'hDEADBEEF);

        // Misaligned load and out-of-range store
        txn(1'b0, 13'h013, 32'h0, 0);
        txn(1'b1, 13'h1000, 32'h12345678, 0);
        check("cnt_err_two", 32'(c1_err), 32'd2);

        // Backpressure with ignored request pulses
        txn(1'b0, 13'h020, 32'h0, 5);
        txn(1'b1, 13'h024, 32'hCAFEF00D, 5);

        // Reset in ISSUE of a store: strobe drops at once, nothing written
        b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_addr = 13'h040; b1.req_wdata = 32'h0BADF00D;
        @(negedge clk);
        b1.req_valid = 1'b0;
        check("issue_mem_mode", 32'(b1.mem_mode), 32'd1);
        check("issue_mem_wdata", b1.mem_wdata, 32'h0BADF00D);
        #1 reset1 = 1'b1;
        #1;
        check("rst_issue_mem_mode", 32'(b1.mem_mode), 32'd0);
        check("rst_issue_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        @(negedge clk);
        reset1 = 1'b0;
        reset_model1();

        // Reset in WAIT of a load
        b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 13'h030;
        @(negedge clk);
        b1.req_valid = 1'b0;
        @(negedge clk);
        #1 reset1 = 1'b1;
        #1;
        check("rst_wait_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        check("rst_wait_mem_mode", 32'(b1.mem_mode), 32'd0);
        check("rst_wait_req_ready", 32'(b1.req_ready), 32'd1);
        check("rst_wait_mem_addr", 32'(b1.mem_addr), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_held_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        end
        reset1 = 1'b0;
        txn(1'b0, 13'h030, 32'h0, 0);
        txn(1'b0, 13'h040, 32'h0, 1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 6));
            case (kind)
                0: a = 13'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                1: a = 13'(32'h1000 + $urandom_range(0, 32'hFFF));
                2: a = 13'h0FFC;
                default: a = 13'($urandom_range(0, 15) * 4);
            endcase
            txn(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
        end

        // Read counter saturation
        force u_dut1.cnt_rd_q = 16'hFFFE;
        #1 release u_dut1.cnt_rd_q;
        m_rd = 32'hFFFE;
        repeat (3) txn(1'b0, 13'($urandom_range(0, 15) * 4), 32'h0, 0);
        check("cnt_rd_saturated", 32'(c1_rd), 32'h0000FFFF);

        // Three-cycle read latency instance
        @(negedge clk);
        load2(12'h010);
        load2(12'h3FC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
